// File: rtl/asp_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asp_irq_ctrl
// Description : Interrupt aggregation for the ASP interrupt lines.
//               Latches rising edges on each used line into a pending
//               register, applies a host-programmable mask and issues one
//               request at a time to the host over a valid/ready handshake,
//               choosing among eligible lines round-robin. A hold-off
//               interval separates consecutive requests.
//               Line map: 0 = DMA_0, 1 = kernel, 2 = DMA_1, 3 = reserved.
// Ports       : clk, reset            - clock, async active-high reset
//               irq_in                - level interrupt sources
//               irq_req_valid/_vector - request to host, line index
//               irq_req_ready         - host accepts request
//               csr_*                 - 64-bit AVMM slave, word addressed
//                                       0 STATUS (W1C), 1 MASK, 2 RAW,
//                                       3 INFLIGHT, 4+i event counter i
// Options     : ASP_IRQ_EVENT_COUNT_EN - adds a 32-bit edge counter per
//               used line at word address 4+i (write clears).
// Revision    : 1.0 - initial release
// ============================================================================
module asp_irq_ctrl #(
    parameter int NUM_LINES      = 4,
    parameter int NUM_USED       = 3,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CSR_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_LINES-1:0]      irq_in,
    output logic                      irq_req_valid,
    output logic [1:0]                irq_req_vector,
    input  logic                      irq_req_ready,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
    input  logic                      csr_read,
    input  logic                      csr_write,
    input  logic [63:0]               csr_writedata,
    input  logic [7:0]                csr_byteenable,
    output logic [63:0]               csr_readdata,
    output logic                      csr_readdatavalid,
    output logic                      csr_waitrequest
);

    // The vector port is 2 bits wide, so line indices wrap naturally mod 4.
    localparam int IDX_W = 2;
    localparam logic [NUM_LINES-1:0] USED_MASK = NUM_LINES'((64'd1 << NUM_USED) - 64'd1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_LINES-1:0]    prev_q, pending_q, pending_d, mask_q, mask_d;
    logic [NUM_LINES-1:0]    issued_q, issued_d;
    logic [7:0]              hold_q, hold_d;
    logic [IDX_W-1:0]        rr_q, rr_d, vector_q, vector_d;
    logic                    valid_q, valid_d;
    logic [63:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;

    logic                    w_wr_en;
    logic [NUM_LINES-1:0]    w_edge, w_clr, w_eligible, w_set_issued;
    logic                    w_pick_found;
    logic [IDX_W-1:0]        w_pick_idx, w_idx;
    logic [63:0]             w_rd_word;
    logic                    w_unused;

    // Only byte 0 carries register fields; a write without it is dropped.
    assign w_wr_en    = csr_write & csr_byteenable[0];
    assign w_edge     = irq_in & ~prev_q & USED_MASK;
    assign w_clr      = (w_wr_en && csr_address == CSR_ADDR_WIDTH'(0))
                        ? csr_writedata[NUM_LINES-1:0] : '0;
    assign w_eligible = pending_q & ~mask_q & ~issued_q;
    assign w_unused   = ^{csr_writedata[63:NUM_LINES], csr_byteenable[7:1]};

    // An edge arriving in the same cycle as its clear keeps the bit set.
    assign pending_d = ((pending_q & ~w_clr) | w_edge) & USED_MASK;
    assign issued_d  = (issued_q & ~w_clr) | w_set_issued;
    assign mask_d    = (w_wr_en && csr_address == CSR_ADDR_WIDTH'(1))
                       ? csr_writedata[NUM_LINES-1:0] : mask_q;

    // Round-robin search starting at the pointer.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_idx        = '0;
        for (int k = 0; k < NUM_LINES; k++) begin
            w_idx = rr_q + IDX_W'(k);
            if (!w_pick_found && w_eligible[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        vector_d     = vector_q;
        hold_d       = hold_q;
        rr_d         = rr_q;
        w_set_issued = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_found) begin
                    vector_d = w_pick_idx;
                    valid_d  = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The request stays up until accepted, even if masked or cleared.
                if (irq_req_ready) begin
                    valid_d                = 1'b0;
                    w_set_issued[vector_q] = 1'b1;
                    rr_d                   = vector_q + IDX_W'(1);
                    hold_d                 = 8'(HOLDOFF_CYCLES - 1);
                    state_d                = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ASP_IRQ_EVENT_COUNT_EN
    logic [31:0] evt_cnt_q [NUM_USED];
    logic [31:0] evt_cnt_d [NUM_USED];

    // A clear write wins over a coincident edge on the same line.
    always_comb begin
        for (int i = 0; i < NUM_USED; i++) begin
            evt_cnt_d[i] = evt_cnt_q[i];
            if (w_wr_en && csr_address == CSR_ADDR_WIDTH'(4 + i)) begin
                evt_cnt_d[i] = 32'd0;
            end else if (w_edge[i]) begin
                evt_cnt_d[i] = evt_cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_USED; i++) evt_cnt_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_USED; i++) evt_cnt_q[i] <= evt_cnt_d[i];
        end
    end
`endif

    always_comb begin
        w_rd_word = 64'd0;
        case (csr_address)
            CSR_ADDR_WIDTH'(0): w_rd_word[NUM_LINES-1:0] = pending_q;
            CSR_ADDR_WIDTH'(1): w_rd_word[NUM_LINES-1:0] = mask_q;
            CSR_ADDR_WIDTH'(2): w_rd_word[NUM_LINES-1:0] = irq_in;
            CSR_ADDR_WIDTH'(3): w_rd_word[2:0]           = {vector_q, valid_q};
            default:            w_rd_word                = 64'd0;
        endcase
`ifdef ASP_IRQ_EVENT_COUNT_EN
        for (int i = 0; i < NUM_USED; i++) begin
            if (csr_address == CSR_ADDR_WIDTH'(4 + i)) begin
                w_rd_word = {32'd0, evt_cnt_q[i]};
            end
        end
`endif
    end

    // Read data is held between reads.
    assign rdata_d  = csr_read ? w_rd_word : rdata_q;
    assign rvalid_d = csr_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            issued_q  <= '0;
            hold_q    <= 8'd0;
            rr_q      <= '0;
            valid_q   <= 1'b0;
            vector_q  <= '0;
            rdata_q   <= 64'd0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            issued_q  <= issued_d;
            hold_q    <= hold_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            vector_q  <= vector_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign irq_req_valid     = valid_q;
    assign irq_req_vector    = vector_q;
    assign csr_readdata      = rdata_q;
    assign csr_readdatavalid = rvalid_q;
    assign csr_waitrequest   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_asp_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_asp_irq_ctrl
// Description : Directed self-checking bench for asp_irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asp_irq_ctrl;

    localparam int HOLDOFF_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq_in = '0;
    logic        irq_req_valid;
    logic [1:0]  irq_req_vector;
    logic        irq_req_ready = 1'b0;
    logic [3:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [63:0] csr_writedata = '0;
    logic [7:0]  csr_byteenable = 8'h01;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;

    int n_checks = 0;
    int n_errors = 0;

    asp_irq_ctrl #(
        .NUM_LINES(4), .NUM_USED(3), .HOLDOFF_CYCLES(HOLDOFF_CYCLES), .CSR_ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .irq_req_valid(irq_req_valid), .irq_req_vector(irq_req_vector),
        .irq_req_ready(irq_req_ready), .csr_address(csr_address),
        .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_byteenable(csr_byteenable), .csr_readdata(csr_readdata),
        .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; irq_in = '0; irq_req_ready = 1'b0;
        csr_read = 1'b0; csr_write = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic csr_wr(input logic [3:0] addr, input logic [63:0] data);
        csr_address = addr; csr_writedata = data; csr_write = 1'b1;
        tick(1);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] addr, output logic [63:0] data);
        csr_address = addr; csr_read = 1'b1;
        tick(1);
        csr_read = 1'b0;
        check_val("rdvalid", {63'd0, csr_readdatavalid}, 64'd1);
        data = csr_readdata;
    endtask

    task automatic pulse(input logic [3:0] lines);
        irq_in = lines;
        tick(1);
        irq_in = '0;
    endtask

    task automatic wait_valid(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (irq_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [63:0] rd;
    logic        ok;
    logic        bad;
    int          gap;

    initial begin
        // ---- reset values
        tick(2);
        reset = 1'b0;
        tick(1);
        check_val("rst_valid", {63'd0, irq_req_valid}, 64'd0);
        check_val("rst_vector", {62'd0, irq_req_vector}, 64'd0);
        check_val("rst_rdata", csr_readdata, 64'd0);
        check_val("rst_rdvalid", {63'd0, csr_readdatavalid}, 64'd0);
        check_val("waitreq", {63'd0, csr_waitrequest}, 64'd0);
        csr_rd(4'd1, rd);
        check_val("rst_mask", rd, 64'hF);
        tick(1);
        check_val("rdvalid_pulse", {63'd0, csr_readdatavalid}, 64'd0);
        check_val("rdata_held", csr_readdata, 64'hF);

        // ---- single line request with stalled handshake
        csr_wr(4'd1, 64'h0);
        pulse(4'b0010);
        wait_valid(3, ok);
        check_val("t1_valid", {63'd0, ok}, 64'd1);
        check_val("t1_vector", {62'd0, irq_req_vector}, 64'd1);
        csr_rd(4'd0, rd);
        check_val("t1_status", rd, 64'h2);
        csr_rd(4'd3, rd);
        check_val("t1_inflight", rd, 64'h3);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!irq_req_valid || irq_req_vector != 2'd1) bad = 1'b1;
        end
        check_val("t1_hold", {63'd0, bad}, 64'd0);
        irq_req_ready = 1'b1;
        tick(1);
        irq_req_ready = 1'b0;
        check_val("t1_drop", {63'd0, irq_req_valid}, 64'd0);

        // ---- two simultaneous lines, round-robin and hold-off spacing
        do_reset();
        csr_wr(4'd1, 64'h0);
        irq_req_ready = 1'b1;
        pulse(4'b0101);
        wait_valid(5, ok);
        check_val("t2_first", {63'd0, ok}, 64'd1);
        check_val("t2_vec0", {62'd0, irq_req_vector}, 64'd0);
        tick(1);                       // acceptance edge
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            gap++;
            if (irq_req_valid) break;
        end
        check_val("t2_gap", 64'(gap), 64'(HOLDOFF_CYCLES + 1));
        check_val("t2_vec2", {62'd0, irq_req_vector}, 64'd2);
        irq_req_ready = 1'b0;

        // ---- masked line, then unmask
        do_reset();
        csr_wr(4'd1, 64'h1);
        pulse(4'b0001);
        tick(3);
        csr_rd(4'd0, rd);
        check_val("t3_status", rd, 64'h1);
        check_val("t3_novalid", {63'd0, irq_req_valid}, 64'd0);
        csr_wr(4'd1, 64'h0);
        wait_valid(4, ok);
        check_val("t3_unmask", {63'd0, ok}, 64'd1);
        check_val("t3_vec", {62'd0, irq_req_vector}, 64'd0);

        // ---- reserved line 3 never pends
        do_reset();
        csr_wr(4'd1, 64'h0);
        pulse(4'b1000);
        tick(4);
        csr_rd(4'd0, rd);
        check_val("t4_status", rd, 64'h0);
        check_val("t4_novalid", {63'd0, irq_req_valid}, 64'd0);
        irq_in = 4'b1010;
        csr_rd(4'd2, rd);
        check_val("t4_raw", rd, 64'hA);
        irq_in = '0;

        // ---- clear vs edge collision, then re-request
        do_reset();
        csr_wr(4'd1, 64'h0);
        pulse(4'b0100);
        wait_valid(4, ok);
        check_val("t5_req", {63'd0, ok}, 64'd1);
        irq_req_ready = 1'b1;
        tick(1);
        irq_req_ready = 1'b0;
        irq_in = 4'b0100;
        csr_wr(4'd0, 64'h4);
        irq_in = '0;
        csr_rd(4'd0, rd);
        check_val("t5_setwins", rd, 64'h4);
        csr_wr(4'd0, 64'h4);
        csr_rd(4'd0, rd);
        check_val("t5_cleared", rd, 64'h0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (irq_req_valid) bad = 1'b1;
        end
        check_val("t5_quiet", {63'd0, bad}, 64'd0);
        pulse(4'b0100);
        wait_valid(4, ok);
        check_val("t5_rereq", {63'd0, ok}, 64'd1);
        check_val("t5_vec", {62'd0, irq_req_vector}, 64'd2);

        // ---- event counters and reset during ISSUE
        do_reset();
        csr_wr(4'd1, 64'h0);
        for (int i = 0; i < 5; i++) begin
            pulse(4'b0001);
            tick(1);
        end
`ifdef ASP_IRQ_EVENT_COUNT_EN
        csr_rd(4'd4, rd);
        check_val("t6_cnt5", rd, 64'd5);
        csr_wr(4'd4, 64'h0);
        csr_rd(4'd4, rd);
        check_val("t6_cnt_clr", rd, 64'd0);
        pulse(4'b0001);
`else
        csr_rd(4'd4, rd);
        check_val("t6_addr4", rd, 64'd0);
`endif
        if (!irq_req_valid) wait_valid(4, ok);
        check_val("t6_issue", {63'd0, irq_req_valid}, 64'd1);
        reset = 1'b1;
        #1;
        check_val("t6_async_drop", {63'd0, irq_req_valid}, 64'd0);
        tick(1);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (irq_req_valid) bad = 1'b1;
        end
        check_val("t6_noresend", {63'd0, bad}, 64'd0);
        csr_rd(4'd1, rd);
        check_val("t6_mask", rd, 64'hF);
        csr_rd(4'd4, rd);
        check_val("t6_cnt_rst", rd, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
